// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer for the async FIFO (read-clock domain).
// It pops words from the FIFO read port and absorbs the FIFO's one-edge read
// latency with a 2-entry buffer, so a ready sink can take one word per clock.
// The words go out as a valid/ready stream, grouped into FRAME_LEN-word frames
// with a last marker. Completed frames are counted, and FIFO underflow sets a
// sticky error flag.
//
// Ports:
//   rd_clk          read-domain clock (rising edge)
//   res_n           asynchronous active-low reset
//   drain_en        permits new FIFO reads
//   fifo_rd_en      FIFO read strobe (combinational from registered state)
//   fifo_rdata      FIFO read data, valid the edge after a sampled strobe
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow flag
//   m_valid/m_data/m_last/m_ready  output stream
//   frame_cnt       completed-frame count, wraps modulo 2^CNT_W
//   err_underflow   sticky underflow error
module fifo_rd_stream #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             rd_clk,
    input  logic             res_n,
    input  logic             drain_en,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             fifo_empty,
    input  logic             fifo_underflow,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             err_underflow
);

    localparam int unsigned BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);

    // Buffer head is m_data itself; tail_q holds the second entry.
    logic [1:0]        occ_q;
    logic              pending_q;
    logic [WIDTH-1:0]  tail_q;
    logic [BEAT_W-1:0] beat_q;

    logic              pop_c;
    logic              push_c;
    logic [2:0]        level_c;
    logic [1:0]        occ_nxt;
    logic [WIDTH-1:0]  head_nxt;
    logic [WIDTH-1:0]  tail_nxt;
    logic [BEAT_W-1:0] beat_nxt;
    logic [CNT_W-1:0]  frame_nxt;

    // Read issue: words held + word in flight - word leaving must stay below 2,
    // so the buffer can never overflow. Reset forces the strobe low.
    always_comb begin
        pop_c      = m_valid & m_ready;
        push_c     = pending_q;
        level_c    = 3'(occ_q) + 3'(pending_q) - 3'(pop_c);
        fifo_rd_en = res_n & drain_en & ~fifo_empty & (level_c < 3'd2);
    end

    // Buffer and framing next state.
    always_comb begin
        occ_nxt   = occ_q;
        head_nxt  = m_data;
        tail_nxt  = tail_q;
        beat_nxt  = beat_q;
        frame_nxt = frame_cnt;

        case ({push_c, pop_c})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_nxt = fifo_rdata;
                end else begin
                    tail_nxt = fifo_rdata;
                end
                occ_nxt = occ_q + 2'd1;
            end
            2'b01: begin
                head_nxt = tail_q;
                occ_nxt  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word queues behind any survivor.
                if (occ_q == 2'd2) begin
                    head_nxt = tail_q;
                    tail_nxt = fifo_rdata;
                end else begin
                    head_nxt = fifo_rdata;
                end
            end
            default: ;
        endcase

        if (pop_c) begin
            if (beat_q == BEAT_LAST) begin
                beat_nxt  = '0;
                frame_nxt = frame_cnt + CNT_W'(1);
            end else begin
                beat_nxt = beat_q + BEAT_W'(1);
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge rd_clk or negedge res_n) begin
        if (!res_n) begin
            occ_q         <= 2'd0;
            pending_q     <= 1'b0;
            tail_q        <= '0;
            beat_q        <= '0;
            m_data        <= '0;
            m_valid       <= 1'b0;
            m_last        <= 1'b0;
            frame_cnt     <= '0;
            err_underflow <= 1'b0;
        end else begin
            occ_q         <= occ_nxt;
            pending_q     <= fifo_rd_en;
            tail_q        <= tail_nxt;
            beat_q        <= beat_nxt;
            m_data        <= head_nxt;
            m_valid       <= (occ_nxt != 2'd0);
            m_last        <= (occ_nxt != 2'd0) && (beat_nxt == BEAT_LAST);
            frame_cnt     <= frame_nxt;
            err_underflow <= err_underflow | fifo_underflow;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (FRAME_LEN=4/CNT_W=16 and
// FRAME_LEN=1/CNT_W=4), each fed by a behavioural FIFO and checked against
// an expected-word queue and arithmetic frame/beat counts.
module tb_fifo_rd_stream;

    localparam int unsigned W    = 8;
    localparam int unsigned FL_A = 4;
    localparam int unsigned CW_A = 16;
    localparam int unsigned FL_B = 1;
    localparam int unsigned CW_B = 4;

    logic clk;
    logic res_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // instance A
    logic          drain_a, rd_en_a, empty_a, unf_a, valid_a, last_a, ready_a, err_a;
    logic [W-1:0]  rdata_a, data_a;
    logic [CW_A-1:0] fcnt_a;
    logic [W-1:0]  mem_a [256];
    logic [7:0]    wp_a, rp_a;

    // instance B
    logic          drain_b, rd_en_b, empty_b, unf_b, valid_b, last_b, ready_b, err_b;
    logic [W-1:0]  rdata_b, data_b;
    logic [CW_B-1:0] fcnt_b;
    logic [W-1:0]  mem_b [256];
    logic [7:0]    wp_b, rp_b;

    fifo_rd_stream #(.WIDTH(W), .FRAME_LEN(FL_A), .CNT_W(CW_A)) dut_a (
        .rd_clk(clk), .res_n(res_n), .drain_en(drain_a), .fifo_rd_en(rd_en_a),
        .fifo_rdata(rdata_a), .fifo_empty(empty_a), .fifo_underflow(unf_a),
        .m_valid(valid_a), .m_data(data_a), .m_last(last_a), .m_ready(ready_a),
        .frame_cnt(fcnt_a), .err_underflow(err_a)
    );

    fifo_rd_stream #(.WIDTH(W), .FRAME_LEN(FL_B), .CNT_W(CW_B)) dut_b (
        .rd_clk(clk), .res_n(res_n), .drain_en(drain_b), .fifo_rd_en(rd_en_b),
        .fifo_rdata(rdata_b), .fifo_empty(empty_b), .fifo_underflow(unf_b),
        .m_valid(valid_b), .m_data(data_b), .m_last(last_b), .m_ready(ready_b),
        .frame_cnt(fcnt_b), .err_underflow(err_b)
    );

    // Behavioural FIFOs: data appears the edge after a sampled strobe.
    assign empty_a = (wp_a == rp_a);
    assign empty_b = (wp_b == rp_b);

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rp_a    <= 8'd0;
            rdata_a <= '0;
        end else if (rd_en_a && !empty_a) begin
            rdata_a <= mem_a[rp_a];
            rp_a    <= rp_a + 8'd1;
        end
    end

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rp_b    <= 8'd0;
            rdata_b <= '0;
        end else if (rd_en_b && !empty_b) begin
            rdata_b <= mem_b[rp_b];
            rp_b    <= rp_b + 8'd1;
        end
    end

    // Reference model state
    logic [W-1:0] exp_a [$];
    logic [W-1:0] exp_b [$];
    int           pops    [2];
    int           strobes [2];
    logic         stall   [2];
    logic [W-1:0] pdata   [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [W-1:0] w);
        if (k == 0) begin
            mem_a[wp_a] = w;
            wp_a = wp_a + 8'd1;
            exp_a.push_back(w);
        end else begin
            mem_b[wp_b] = w;
            wp_b = wp_b + 8'd1;
            exp_b.push_back(w);
        end
    endtask

    task automatic clr_model();
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i < 2; i++) begin
            pops[i]    = 0;
            strobes[i] = 0;
            stall[i]   = 1'b0;
            pdata[i]   = '0;
        end
        wp_a = 8'd0;
        wp_b = 8'd0;
    endtask

    // Per-cycle check of one instance, sampled mid-cycle before the next edge.
    task automatic mon(input int k, input logic v, input logic [W-1:0] d, input logic l,
                       input logic [15:0] fc, input logic r, input logic re, input logic em,
                       input int fl, input int cw);
        logic [W-1:0] e;
        logic         have;
        chk("rd_when_empty", 32'(re & em), 0);
        chk("outstanding_le2", 32'((strobes[k] - pops[k]) <= 2), 1);
        chk("frame_cnt", 32'(fc), 32'((pops[k] / fl) % (1 << cw)));
        if (stall[k]) begin
            chk("hold_valid", 32'(v), 1);
            chk("hold_data", 32'(d), 32'(pdata[k]));
        end
        if (!v) chk("last_idle", 32'(l), 0);
        if (v && r) begin
            have = 1'b0;
            e    = '0;
            if (k == 0 && exp_a.size() > 0) begin
                e = exp_a.pop_front();
                have = 1'b1;
            end else if (k == 1 && exp_b.size() > 0) begin
                e = exp_b.pop_front();
                have = 1'b1;
            end
            if (have) chk("data_order", 32'(d), 32'(e));
            else      chk("spurious_pop", 32'(v & r), 0);
            chk("last_pos", 32'(l), 32'((pops[k] % fl) == fl - 1));
            pops[k]++;
        end
        if (re) strobes[k]++;
        stall[k] = v & ~r;
        pdata[k] = d;
    endtask

    task automatic step();
        #2;
        mon(0, valid_a, data_a, last_a, 16'(fcnt_a), ready_a, rd_en_a, empty_a, FL_A, CW_A);
        mon(1, valid_b, data_b, last_b, 16'(fcnt_b), ready_b, rd_en_b, empty_b, FL_B, CW_B);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_model();
        res_n = 1'b0;
        step();
        step();
        res_n = 1'b1;
    endtask

    initial begin
        int n_valid;
        int first;
        int last_seen;
        int n_last;

        res_n   = 1'b0;
        drain_a = 1'b1;
        drain_b = 1'b1;
        ready_a = 1'b0;
        ready_b = 1'b1;
        unf_a   = 1'b0;
        unf_b   = 1'b0;
        clr_model();
        repeat (3) @(negedge clk);

        // power-on reset values
        chk("por_valid", 32'(valid_a), 0);
        chk("por_data", 32'(data_a), 0);
        chk("por_last", 32'(last_a), 0);
        chk("por_fcnt", 32'(fcnt_a), 0);
        chk("por_err", 32'(err_a), 0);
        chk("por_rd_en", 32'(rd_en_a), 0);
        res_n = 1'b1;

        // fill buffer under backpressure, then reset mid-stream
        push(0, 8'hA1);
        push(0, 8'hA2);
        push(0, 8'hA3);
        repeat (5) step();
        chk("fill_valid", 32'(valid_a), 1);
        chk("fill_head", 32'(data_a), 32'h0A1);
        chk("fill_rd_off", 32'(rd_en_a), 0);
        clr_model();
        res_n = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_data", 32'(data_a), 0);
        chk("rst_last", 32'(last_a), 0);
        chk("rst_fcnt", 32'(fcnt_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_rd_en", 32'(rd_en_a), 0);
        step();
        step();
        res_n = 1'b1;

        // read latency: strobe, then data visible two edges later
        ready_a = 1'b1;
        push(0, 8'h11);
        #1;
        chk("lat_strobe", 32'(rd_en_a), 1);
        chk("lat_v0", 32'(valid_a), 0);
        step();
        chk("lat_v_e1", 32'(valid_a), 0);
        step();
        chk("lat_v_e2", 32'(valid_a), 1);
        chk("lat_data", 32'(data_a), 32'h11);
        step();

        // streaming 0x01..0x08 at full rate
        do_reset();
        ready_a = 1'b1;
        for (int i = 1; i <= 8; i++) push(0, 8'(i));
        n_valid = 0;
        first = -1;
        last_seen = -1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (valid_a) begin
                n_valid++;
                if (first < 0) first = c;
                last_seen = c;
            end
        end
        chk("stream_cnt", 32'(n_valid), 8);
        chk("stream_span", 32'(last_seen - first + 1), 8);
        chk("stream_frames", 32'(fcnt_a), 2);

        // backpressure: two reads outstanding, then toggle ready
        do_reset();
        ready_a = 1'b0;
        for (int i = 1; i <= 6; i++) push(0, 8'(8'h20 + i));
        repeat (6) step();
        chk("bp_strobes", 32'(strobes[0]), 2);
        chk("bp_rd_off", 32'(rd_en_a), 0);
        chk("bp_head", 32'(data_a), 32'h21);
        for (int c = 0; c < 30; c++) begin
            ready_a = ~ready_a;
            step();
        end
        chk("bp_pops", 32'(pops[0]), 6);
        chk("bp_left", 32'(exp_a.size()), 0);

        // drain_en dropped right after a strobe
        do_reset();
        ready_a = 1'b1;
        push(0, 8'h31);
        push(0, 8'h32);
        push(0, 8'h33);
        #1;
        chk("dr_strobe", 32'(rd_en_a), 1);
        step();
        drain_a = 1'b0;
        #1;
        chk("dr_stop", 32'(rd_en_a), 0);
        repeat (6) step();
        chk("dr_pops", 32'(pops[0]), 1);
        chk("dr_strobes", 32'(strobes[0]), 1);
        drain_a = 1'b1;
        repeat (8) step();
        chk("dr_resume", 32'(pops[0]), 3);

        // underflow: sticky through random traffic, cleared by reset
        unf_a = 1'b1;
        step();
        unf_a = 1'b0;
        chk("unf_set", 32'(err_a), 1);
        chk("unf_other", 32'(err_b), 0);
        for (int c = 0; c < 100; c++) begin
            if ($urandom_range(1, 0) != 0) push(0, 8'($urandom));
            ready_a = 1'($urandom_range(1, 0));
            drain_a = 1'($urandom_range(3, 0) != 0);
            step();
            chk("unf_sticky", 32'(err_a), 1);
        end
        drain_a = 1'b1;
        ready_a = 1'b1;
        repeat (130) step();
        chk("rand_drained", 32'(exp_a.size()), 0);
        do_reset();
        chk("unf_clr", 32'(err_a), 0);

        // frame counter wrap on the FRAME_LEN=1, CNT_W=4 instance
        ready_b = 1'b1;
        for (int i = 0; i < 17; i++) push(1, 8'(8'h40 + i));
        n_valid = 0;
        n_last  = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (valid_b) begin
                n_valid++;
                if (last_b) n_last++;
            end
        end
        chk("wrap_pops", 32'(pops[1]), 17);
        chk("wrap_fcnt", 32'(fcnt_b), 1);
        chk("wrap_last_all", 32'(n_last), 17);
        chk("wrap_valid_cnt", 32'(n_valid), 17);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
